// File: rtl/dct_pkg.sv
// Shared constants and state type for the 8x8 DCT coefficient MAC.
package dct_pkg;

  localparam int DCT_N = 8;
  localparam int COS_FRAC_BITS = 8;

  localparam logic [7:0] ALPHA_DC   = 8'd32;
  localparam logic [7:0] ALPHA_EDGE = 8'd45;
  localparam logic [7:0] ALPHA_AC   = 8'd64;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    SCALE = 2'd1,
    OUT   = 2'd2
  } dct_state_t;

  function automatic logic [7:0] alpha_q8(input int k1, input int k2);
    if (k1 == 0 && k2 == 0) return ALPHA_DC;
    if (k1 == 0 || k2 == 0) return ALPHA_EDGE;
    return ALPHA_AC;
  endfunction

endpackage

// File: rtl/dct_coef_mac.sv
// One DCT coefficient F(K1,K2) accumulated over a raster 8x8 block.
// Define DCT_LEVEL_SHIFT_EN to subtract 128 from every pixel.
module dct_coef_mac
  import dct_pkg::*;
#(
  parameter int K1 = 0,
  parameter int K2 = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_pixel,
  output logic [2:0]         n1,
  output logic [2:0]         n2,
  input  logic signed [31:0] cos_term,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [31:0] out_coef
);

  localparam logic [7:0] ALPHA = alpha_q8(K1, K2);
  localparam logic [5:0] LAST = 6'(DCT_N * DCT_N - 1);
  localparam int SHIFT = 2 * COS_FRAC_BITS;
  localparam logic signed [39:0] ROUND =
    40'sd1 <<< (SHIFT - 1);

  dct_state_t state;
  dct_state_t state_nx;

  logic [5:0]         cnt;
  logic signed [31:0] acc;
  logic signed [8:0]  pix_s;
  logic signed [31:0] pix_w;
  logic signed [31:0] prod;
  logic signed [39:0] acc_w;
  logic signed [39:0] alpha_w;
  logic signed [39:0] scaled;
  logic               beat;

  assign n1 = cnt[5:3];
  assign n2 = cnt[2:0];
  assign beat = in_valid && in_ready;

`ifdef DCT_LEVEL_SHIFT_EN
  assign pix_s = {1'b0, in_pixel} - 9'd128;
`else
  assign pix_s = {1'b0, in_pixel};
`endif

  assign pix_w = {{23{pix_s[8]}}, pix_s};
  assign prod = pix_w * cos_term;

  // Q8 alpha times Q8 cos needs a rounded 16-bit drop.
  assign acc_w = {{8{acc[31]}}, acc};
  assign alpha_w = {32'd0, ALPHA};
  assign scaled = acc_w * alpha_w + ROUND;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ACCUM: if (beat && cnt == LAST)
               state_nx = SCALE;
      SCALE: state_nx = OUT;
      OUT:   if (out_ready)
               state_nx = ACCUM;
      default: state_nx = ACCUM;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      ACCUM:   in_ready = 1'b1;
      OUT:     out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      acc <= '0;
      out_coef <= '0;
    end else begin
      if (beat) begin
        acc <= acc + prod;
        cnt <= cnt + 6'd1;
      end
      if (state == SCALE)
        out_coef <= 32'(scaled >>> SHIFT);
      if (state == OUT && out_ready)
        acc <= '0;
    end
  end

endmodule

// File: tb/tb_dct_coef_mac.sv
// Self-checking bench for dct_coef_mac with a real-valued cos LUT model.
module tb_dct_coef_mac;

  localparam int TK1 = 0;
  localparam int TK2 = 2;
  localparam real PI = 3.14159265358979323846;
`ifdef DCT_LEVEL_SHIFT_EN
  localparam int FULL = 128;
`else
  localparam int FULL = 255;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  logic in_ready;
  logic [7:0] in_pixel;
  logic [2:0] n1;
  logic [2:0] n2;
  logic signed [31:0] cos_term;
  logic out_valid;
  logic out_ready;
  logic signed [31:0] out_coef;

  int n_chk = 0;
  int n_fail = 0;

  dct_coef_mac #(.K1(TK1), .K2(TK2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_pixel(in_pixel),
    .n1(n1),
    .n2(n2),
    .cos_term(cos_term),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_coef(out_coef)
  );

  always #5 clk = ~clk;

  function automatic int lut(input int r, input int c);
    real v;
    v = 256.0 * $cos((2.0 * r + 1.0) * TK1 * PI / 16.0)
              * $cos((2.0 * c + 1.0) * TK2 * PI / 16.0);
    return $rtoi(v);
  endfunction

  always_comb cos_term = lut(int'(n1), int'(n2));

  function automatic longint pixs(input int p);
`ifdef DCT_LEVEL_SHIFT_EN
    return longint'(p) - 128;
`else
    return longint'(p);
`endif
  endfunction

  function automatic int golden(input int p[64]);
    longint a = 0;
    longint alpha;
    for (int i = 0; i < 64; i++)
      a += pixs(p[i]) * lut(i / 8, i % 8);
    if (TK1 == 0 && TK2 == 0) alpha = 32;
    else if (TK1 == 0 || TK2 == 0) alpha = 45;
    else alpha = 64;
    return int'((a * alpha + 32768) >>> 16);
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic feed(input int p[64], input int nb, input int gap);
    int i = 0;
    int to = 0;
    logic hs;
    while (i < nb) begin
      in_valid = ($urandom_range(99) >= gap);
      in_pixel = 8'(p[i]);
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) begin
        i++;
        to = 0;
      end else if (++to > 200) begin
        chk("feed_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic collect(input int exp, input int stall, input string name);
    int lat = 1;
    int bad = 0;
    logic signed [31:0] held;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_lat"}, lat, 2);
    held = out_coef;
    out_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      if (!out_valid || out_coef != held || in_ready) bad++;
    end
    if (stall > 0) chk({name, "_stall"}, bad, 0);
    chk(name, out_coef, exp);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, "_rel"}, {in_ready, out_valid}, 2'b10);
  endtask

  typedef struct {
    int    kind;
    int    exp;
    string name;
  } vec_t;

  function automatic void fill(input int kind, output int p[64]);
    for (int i = 0; i < 64; i++)
      case (kind)
        0: p[i] = (i % 8 == 0) ? 100 : 0;
        1: p[i] = (i == 0) ? 255 : 0;
        default: p[i] = FULL;
      endcase
  endfunction

  function automatic void rnd(output int p[64]);
    for (int i = 0; i < 64; i++) p[i] = int'($urandom_range(255));
  endfunction

  initial begin
    vec_t vt[3];
    int blk[64];
    int blk2[64];
    int q[$];
    int beats, idle, cyc;
    logic hs;

    vt[0] = '{0, 130, "col0_100"};
    vt[1] = '{1, 41, "dc_255"};
    vt[2] = '{2, 0, "flat"};

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_pixel = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_coef", out_coef, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1);

    for (int v = 0; v < 3; v++) begin
      fill(vt[v].kind, blk);
      feed(blk, 64, 0);
      collect(vt[v].exp, 0, vt[v].name);
    end

    for (int r = 0; r < 3; r++) begin
      rnd(blk);
      feed(blk, 64, 30);
      collect(golden(blk), (r == 0) ? 10 : r * 3, "rand");
    end

    rnd(blk);
    feed(blk, 64, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("pend_out_valid", out_valid, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("pend_rst_valid", out_valid, 0);
    rst_n = 1'b1;
    feed(blk, 30, 20);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_valid", out_valid, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    rnd(blk);
    feed(blk, 64, 25);
    collect(golden(blk), 2, "after_rst");

    rnd(blk);
    rnd(blk2);
    beats = 0;
    idle = 0;
    cyc = 0;
    out_ready = 1'b1;
    while ((beats < 128 || q.size() < 2) && cyc < 400) begin
      in_valid = (beats < 128);
      in_pixel = (beats < 64) ? 8'(blk[beats]) :
                 (beats < 128) ? 8'(blk2[beats - 64]) : 8'd0;
      hs = in_valid && in_ready;
      if (beats == 64 && !in_ready) idle++;
      if (out_valid) q.push_back(out_coef);
      @(posedge clk); #1;
      if (hs) beats++;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("b2b_count", q.size(), 2);
    chk("b2b_idle", idle, 2);
    chk("b2b_coef0", (q.size() > 0) ? q[0] : -1, golden(blk));
    chk("b2b_coef1", (q.size() > 1) ? q[1] : -1, golden(blk2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
